// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//
// Shared types and helpers for the async-FIFO write-side arbiter.
//
// Contents:
//   arb_state_t  - arbiter FSM state (ARB_IDLE, ARB_BURST)
//   BEAT_CNT_W   - width of the optional accepted-beat counter
//   MAX_REQ      - largest supported requester count
//   rr_pick()    - round-robin priority pick over up to MAX_REQ requesters
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam int BEAT_CNT_W = 16;
  localparam int MAX_REQ    = 16;

  // Returns the index of the first set bit of req when scanning upward from
  // rr_ptr and wrapping at num_req. The scan runs from the farthest offset
  // back to the nearest so that the nearest set bit overwrites the result.
  // rr_ptr is always below num_req, so a single subtraction wraps it.
  // Returns 0 when no bit is set; callers qualify with their own found flag.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [3:0]         rr_ptr,
                                         input int                 num_req);
    logic [3:0] pick;
    int         idx;
    pick = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < num_req) begin
        idx = int'(rr_ptr) + k;
        if (idx >= num_req) begin
          idx = idx - num_req;
        end
        if (req[idx[3:0]]) begin
          pick = idx[3:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// fifo_arb_rr_pick
//
// Purely combinational round-robin priority picker.
//
// Parameters:
//   NUM_REQ  number of requesters (2..16)
//   IDX_W    derived index width
//
// Ports:
//   req     in   NUM_REQ  request vector to choose from
//   rr_ptr  in   IDX_W    requester with the highest priority this time
//   idx     out  IDX_W    chosen requester (valid when found)
//   found   out  1        at least one request is set
// ---------------------------------------------------------------------------
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // The package helper works on the widest supported vector, so the inputs
  // are zero-extended on the way in and the index trimmed on the way out.
  always_comb begin
    idx   = IDX_W'(rr_pick(16'(req), 4'(rr_ptr), NUM_REQ));
    found = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the single write port of the async FIFO between NUM_REQ requesters
// in the wclk domain. Grants are handed out round-robin and held for a whole
// packet (until the accepted beat flagged last), so packets never interleave
// inside the FIFO. Arbitration costs one bubble cycle in IDLE. After that,
// beats stream one per cycle while the owner requests and the FIFO is not
// full.
//
// Parameters:
//   DATA_WIDTH  width of one beat (matches the FIFO)
//   NUM_REQ     number of requesters (2..16)
//   IDX_W       derived requester index width
//
// Ports:
//   wclk      in   1                   write-domain clock (rising edge)
//   wrst      in   1                   synchronous active-high reset
//   req       in   NUM_REQ             per-requester beat valid
//   last      in   NUM_REQ             per-requester end of packet (with req)
//   data      in   NUM_REQ*DATA_WIDTH  per-requester beat, slice i at
//                                      [i*DATA_WIDTH +: DATA_WIDTH]
//   ack       out  NUM_REQ             beat accepted this cycle (one-hot/0)
//   gnt       out  NUM_REQ             registered one-hot owner, 0 when idle
//   winc      out  1                   FIFO write strobe
//   wdata     out  DATA_WIDTH          FIFO write data
//   wfull     in   1                   FIFO full, already in wclk domain
//   busy      out  1                   high while a packet owns the port
//   beat_cnt  out  16                  saturating accepted-beat count
//                                      (only with FIFO_ARB_BEAT_CNT_EN)
//
// Configuration macro:
//   FIFO_ARB_BEAT_CNT_EN  adds the beat_cnt port and its counter.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          wfull,
  output logic                          busy
`ifdef FIFO_ARB_BEAT_CNT_EN
  ,
  output logic [BEAT_CNT_W-1:0]         beat_cnt
`endif
);

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             accept;
  logic             end_pkt;
  logic [IDX_W-1:0] next_ptr;

  fifo_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // A beat is taken only from the current owner, only in BURST, and only
  // when the FIFO has room. Reset also blocks the strobe so nothing of an
  // abandoned packet reaches the FIFO while wrst is high. Non-owners never
  // see an ack because ack is derived from the one-hot grant.
  always_comb begin
    accept   = (state == ARB_BURST) && req[owner] && !wfull && !wrst;
    end_pkt  = accept && last[owner];
    winc     = accept;
    ack      = accept ? gnt : '0;
    wdata    = data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
  end

  // Arbiter FSM. IDLE latches the round-robin winner as the owner. BURST
  // holds the grant through stalls (full FIFO or owner pausing) and releases
  // only on the accepted last beat. At release, the requester after the
  // owner gets top priority next time.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      gnt    <= '0;
      rr_ptr <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            state <= ARB_BURST;
            owner <= pick_idx;
            gnt   <= NUM_REQ'(1) << pick_idx;
            busy  <= 1'b1;
          end
        end
        ARB_BURST: begin
          if (end_pkt) begin
            state  <= ARB_IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end
        end
        default: begin
          state <= ARB_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_BEAT_CNT_EN
  logic [BEAT_CNT_W-1:0] beat_cnt_q;

  // Counts every beat written into the FIFO. It sticks at all-ones instead
  // of wrapping, so a long run still reads as "at least this many".
  always_ff @(posedge wclk) begin
    if (wrst) begin
      beat_cnt_q <= '0;
    end else if (accept && (beat_cnt_q != '1)) begin
      beat_cnt_q <= beat_cnt_q + BEAT_CNT_W'(1);
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// It keeps a packet-level reference model of the arbiter: an owner number,
// a priority pointer and a beat count. A per-cycle compare process checks
// the DUT against that model. Directed scenarios add literal expectations.
// Define FIFO_ARB_BEAT_CNT_EN to also exercise the beat counter.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            wclk;
  logic            wrst;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*DW-1:0] data;
  logic [N-1:0]    ack;
  logic [N-1:0]    gnt;
  logic            winc;
  logic [DW-1:0]   wdata;
  logic            wfull;
  logic            busy;
`ifdef FIFO_ARB_BEAT_CNT_EN
  logic [15:0]     beat_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;
  bit record_order = 0;

  // Reference model state: owner < 0 means no packet owns the port.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  // Writes seen by the FIFO and the grant order, used for literal checks.
  logic [7:0] wr_data_q[$];
  int         wr_src_q[$];
  int         gnt_order_q[$];
  logic [N-1:0] prev_gnt = '0;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N)
  ) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .req      (req),
    .last     (last),
    .data     (data),
    .ack      (ack),
    .gnt      (gnt),
    .winc     (winc),
    .wdata    (wdata),
    .wfull    (wfull),
    .busy     (busy)
`ifdef FIFO_ARB_BEAT_CNT_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  function automatic logic [N*DW-1:0] mk_data(input int i, input logic [7:0] b);
    logic [N*DW-1:0] d;
    d = '0;
    d[i*DW +: DW] = b;
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge. The task returns with
  // them settled, before the falling edge, so literal checks see the cycle.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] r,
                               input logic [N-1:0] l, input logic [N*DW-1:0] d,
                               input logic f);
    @(posedge wclk);
    #1;
    wrst  = rst;
    req   = r;
    last  = l;
    data  = d;
    wfull = f;
    #2;
  endtask

  // Reference model: packet-level rules, advanced once per rising edge.
  always @(posedge wclk) begin : model
    int i;
    bit found;
    if (wrst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!found && req[i]) begin
          found   = 1;
          m_owner = i;
        end
      end
    end else if (req[m_owner] && !wfull) begin
      if (m_cnt < 65535) m_cnt++;
      if (last[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  // FIFO sink: capture every write strobe and who it came from.
  always @(posedge wclk) begin
    if (winc === 1'b1) begin
      wr_data_q.push_back(wdata);
      wr_src_q.push_back(oh_idx(ack));
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge wclk) begin : compare
    logic       exp_acc;
    logic [N-1:0] exp_gnt;
    if (check_en) begin
      exp_acc = !wrst && (m_owner >= 0) && req[m_owner] && !wfull;
      exp_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
      checkOutput("busy", 32'(busy), 32'(m_owner >= 0));
      checkOutput("winc", 32'(winc), 32'(exp_acc));
      checkOutput("ack", 32'(ack), exp_acc ? 32'(exp_gnt) : 32'd0);
      if (exp_acc) begin
        checkOutput("wdata", 32'(wdata), 32'(data[m_owner*DW +: DW]));
      end
`ifdef FIFO_ARB_BEAT_CNT_EN
      checkOutput("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
`endif
    end
    if (record_order && gnt != '0 && prev_gnt == '0) begin
      gnt_order_q.push_back(oh_idx(gnt));
    end
    prev_gnt = gnt;
  end

  task automatic doReset();
    applyStimulus(1'b1, '0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin : main
    int exp_src[10];
    logic [7:0] exp_dat[3];
    wrst  = 1'b1;
    req   = '0;
    last  = '0;
    data  = '0;
    wfull = 1'b0;

    // Reset state, then a single-beat packet from requester 0.
    doReset();
    check_en = 1;
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_winc", 32'(winc), 32'd0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, mk_data(0, 8'hA5), 1'b0);
    checkOutput("t1_idle_winc", 32'(winc), 32'd0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, mk_data(0, 8'hA5), 1'b0);
    checkOutput("t1_gnt", 32'(gnt), 32'h1);
    checkOutput("t1_winc", 32'(winc), 32'd1);
    checkOutput("t1_wdata", 32'(wdata), 32'hA5);
    checkOutput("t1_ack", 32'(ack), 32'h1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, '0, 1'b0);
    checkOutput("t1_end_gnt", 32'(gnt), 32'd0);
    checkOutput("t1_end_busy", 32'(busy), 32'd0);

    // All four request, two-beat packets: order 0,1,2,3,0.
    doReset();
    wr_src_q.delete();
    wr_data_q.delete();
    gnt_order_q.delete();
    record_order = 1;
    for (int p = 0; p < 5; p++) begin
      applyStimulus(1'b0, 4'b1111, 4'b0000, 32'h30201000, 1'b0);
      applyStimulus(1'b0, 4'b1111, 4'b0000, 32'h30201000, 1'b0);
      applyStimulus(1'b0, 4'b1111, 4'b1111, 32'h31211101, 1'b0);
    end
    applyStimulus(1'b0, 4'b0000, 4'b0000, '0, 1'b0);
    record_order = 0;
    exp_src = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    checkOutput("t2_order_len", 32'(gnt_order_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t2_order%0d", i),
                  (i < gnt_order_q.size()) ? 32'(gnt_order_q[i]) : 32'hFF,
                  32'(exp_src[2*i]));
    end
    checkOutput("t2_writes", 32'(wr_src_q.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t2_src%0d", i),
                  (i < wr_src_q.size()) ? 32'(wr_src_q[i]) : 32'hFF,
                  32'(exp_src[i]));
    end

    // Requester 2, three beats, FIFO full for three cycles on beat two.
    doReset();
    wr_data_q.delete();
    applyStimulus(1'b0, 4'b0100, 4'b0000, mk_data(2, 8'h10), 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'b0000, mk_data(2, 8'h10), 1'b0);
    checkOutput("t3_first_winc", 32'(winc), 32'd1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'b0100, 4'b0000, mk_data(2, 8'h11), 1'b1);
      checkOutput("t3_full_winc", 32'(winc), 32'd0);
      checkOutput("t3_full_ack", 32'(ack), 32'd0);
      checkOutput("t3_full_gnt", 32'(gnt), 32'h4);
    end
    applyStimulus(1'b0, 4'b0100, 4'b0000, mk_data(2, 8'h11), 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'b0100, mk_data(2, 8'h12), 1'b0);
    checkOutput("t3_last_gnt", 32'(gnt), 32'h4);
    applyStimulus(1'b0, 4'b0000, 4'b0000, '0, 1'b0);
    exp_dat = '{8'h10, 8'h11, 8'h12};
    checkOutput("t3_writes", 32'(wr_data_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t3_data%0d", i),
                  (i < wr_data_q.size()) ? 32'(wr_data_q[i]) : 32'hFFF,
                  32'(exp_dat[i]));
    end

    // Requester 1 pauses mid-packet while requester 3 waits.
    doReset();
    applyStimulus(1'b0, 4'b0010, 4'b0000, mk_data(1, 8'h21), 1'b0);
    applyStimulus(1'b0, 4'b0010, 4'b0000, mk_data(1, 8'h21), 1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 4'b1000, 4'b1000, mk_data(3, 8'h3F), 1'b0);
      checkOutput("t4_pause_gnt", 32'(gnt), 32'h2);
      checkOutput("t4_pause_ack", 32'(ack), 32'd0);
      checkOutput("t4_pause_winc", 32'(winc), 32'd0);
    end
    applyStimulus(1'b0, 4'b1010, 4'b0010, mk_data(1, 8'h22), 1'b0);
    checkOutput("t4_resume_ack", 32'(ack), 32'h2);
    applyStimulus(1'b0, 4'b1000, 4'b0000, mk_data(3, 8'h33), 1'b0);
    applyStimulus(1'b0, 4'b1000, 4'b0000, mk_data(3, 8'h33), 1'b0);
    checkOutput("t4_next_gnt", 32'(gnt), 32'h8);

    // Reset in the middle of requester 3's packet.
    applyStimulus(1'b1, 4'b1000, 4'b0000, mk_data(3, 8'h34), 1'b0);
    applyStimulus(1'b0, 4'b1001, 4'b0000, '0, 1'b0);
    checkOutput("t5_rst_gnt", 32'(gnt), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_winc", 32'(winc), 32'd0);
    applyStimulus(1'b0, 4'b1001, 4'b0000, '0, 1'b0);
    checkOutput("t5_first_gnt", 32'(gnt), 32'h1);

`ifdef FIFO_ARB_BEAT_CNT_EN
    // Saturation of the beat counter, then clear by reset.
    doReset();
    applyStimulus(1'b0, 4'b0001, 4'b0000, mk_data(0, 8'h55), 1'b0);
    for (int c = 0; c < 70000; c++) begin
      applyStimulus(1'b0, 4'b0001, 4'b0000, mk_data(0, 8'h55), 1'b0);
    end
    applyStimulus(1'b0, 4'b0000, 4'b0000, '0, 1'b0);
    checkOutput("cnt_sat", 32'(beat_cnt), 32'hFFFF);
    doReset();
    checkOutput("cnt_clr", 32'(beat_cnt), 32'd0);
`endif

    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
